// File: rtl/sop_pkg.sv
// Shared types and defaults for the sum-of-products evaluator.
// Term masks are stored at a fixed maximum width and zero-extended.
package sop_pkg;

    localparam int SOP_NUM_IN    = 5;
    localparam int SOP_NUM_TERMS = 6;
    localparam int SOP_MAX_IN    = 16;

    typedef struct packed {
        logic [SOP_MAX_IN-1:0] pos;
        logic [SOP_MAX_IN-1:0] neg;
        logic                  en;
    } term_cfg_t;

    localparam term_cfg_t TERM_CFG_RST = '{
        pos: '0,
        neg: '0,
        en:  1'b0
    };

    function automatic logic term_match(
        input term_cfg_t             cfg,
        input logic [SOP_MAX_IN-1:0] smp
    );
        logic pos_ok;
        logic neg_ok;
        pos_ok = ((smp & cfg.pos) == cfg.pos);
        neg_ok = ((smp & cfg.neg) == '0);
        return cfg.en && pos_ok && neg_ok;
    endfunction

endpackage

// File: rtl/sop_term.sv
// Combinational match of one sample against one product term.
// Overlapping pos/neg bits can never both be satisfied, so such a term never hits.
module sop_term
    import sop_pkg::*;
#(
    parameter int NUM_IN = SOP_NUM_IN
) (
    input  term_cfg_t         cfg_i,
    input  logic [NUM_IN-1:0] data_i,
    output logic              hit_o
);

    logic [SOP_MAX_IN-1:0] data_ext;

    assign data_ext = SOP_MAX_IN'(data_i);
    assign hit_o    = term_match(cfg_i, data_ext);

endmodule

// File: rtl/sop_eval.sv
// Programmable sum-of-products evaluator: term config table feeding a
// two-stage valid/ready pipeline (S1 = term hits, S2 = hits + OR).
module sop_eval
    import sop_pkg::*;
#(
    parameter int NUM_IN    = SOP_NUM_IN,
    parameter int NUM_TERMS = SOP_NUM_TERMS,
    localparam int TW = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_we,
    input  logic [TW-1:0]        cfg_term,
    input  logic [NUM_IN-1:0]    cfg_pos,
    input  logic [NUM_IN-1:0]    cfg_neg,
    input  logic                 cfg_en,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NUM_IN-1:0]    in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_y,
    output logic [NUM_TERMS-1:0] out_hits
);

    term_cfg_t cfg_q [NUM_TERMS];
    term_cfg_t cfg_d [NUM_TERMS];

    logic                 s1_valid_q, s1_valid_d;
    logic [NUM_TERMS-1:0] s1_hits_q,  s1_hits_d;
    logic                 s2_valid_q, s2_valid_d;
    logic [NUM_TERMS-1:0] s2_hits_q,  s2_hits_d;
    logic                 s2_y_q,     s2_y_d;

    logic [NUM_TERMS-1:0] hits_c;
    logic                 s1_adv;
    logic                 s2_adv;
    logic                 accept;

    for (genvar g = 0; g < NUM_TERMS; g++) begin : g_term
        sop_term #(
            .NUM_IN(NUM_IN)
        ) u_term (
            .cfg_i  (cfg_q[g]),
            .data_i (in_data),
            .hit_o  (hits_c[g])
        );
    end

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = rst_n && s1_adv;
    assign accept   = in_valid && in_ready;

    assign out_valid = s2_valid_q;
    assign out_y     = s2_y_q;
    assign out_hits  = s2_hits_q;

    // Out-of-range indices match no entry, so those writes fall away.
    always_comb begin
        cfg_d = cfg_q;
        if (cfg_we) begin
            for (int t = 0; t < NUM_TERMS; t++) begin
                if (int'(cfg_term) == t) begin
                    cfg_d[t].pos = SOP_MAX_IN'(cfg_pos);
                    cfg_d[t].neg = SOP_MAX_IN'(cfg_neg);
                    cfg_d[t].en  = cfg_en;
                end
            end
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_hits_d  = s1_hits_q;
        s2_valid_d = s2_valid_q;
        s2_hits_d  = s2_hits_q;
        s2_y_d     = s2_y_q;
        if (s1_adv) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_hits_d = hits_c;
            end
        end
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_hits_d = s1_hits_q;
                s2_y_d    = |s1_hits_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int t = 0; t < NUM_TERMS; t++) begin
                cfg_q[t] <= TERM_CFG_RST;
            end
            s1_valid_q <= 1'b0;
            s1_hits_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_hits_q  <= '0;
            s2_y_q     <= 1'b0;
        end else begin
            for (int t = 0; t < NUM_TERMS; t++) begin
                cfg_q[t] <= cfg_d[t];
            end
            s1_valid_q <= s1_valid_d;
            s1_hits_q  <= s1_hits_d;
            s2_valid_q <= s2_valid_d;
            s2_hits_q  <= s2_hits_d;
            s2_y_q     <= s2_y_d;
        end
    end

endmodule

// File: doc/sop_eval.md
SOP_EVAL -- requirements
Module: sop_eval

Interface
REQ-001 SHALL have parameter NUM_IN, default 5, number of boolean inputs per sample.
REQ-002 SHALL have parameter NUM_TERMS, default 6, number of programmable product terms.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port cfg_we  input  1  term configuration write strobe.
REQ-006 SHALL have port cfg_term  input  $clog2(NUM_TERMS)  index of term written.
REQ-007 SHALL have port cfg_pos  input  NUM_IN  bits that must be 1 for the term.
REQ-008 SHALL have port cfg_neg  input  NUM_IN  bits that must be 0 for the term.
REQ-009 SHALL have port cfg_en  input  1  term enable written with the masks.
REQ-010 SHALL have port in_valid  input  1  in_data valid.
REQ-011 SHALL have port in_ready  output  1  block accepts sample this cycle.
REQ-012 SHALL have port in_data  input  NUM_IN  sample, bit i = input i.
REQ-013 SHALL have port out_valid  output  1  result valid.
REQ-014 SHALL have port out_ready  input  1  consumer accepts result.
REQ-015 SHALL have port out_y  output  1  OR of all term hits.
REQ-016 SHALL have port out_hits  output  NUM_TERMS  per-term hit vector.

Function
REQ-017 Term t SHALL hit iff enabled, every cfg_pos bit is 1 in sample, every cfg_neg bit is 0 in sample.
REQ-018 Enabled term with pos=neg=0 SHALL always hit; term with pos&neg nonzero SHALL never hit; disabled term SHALL never hit.
REQ-019 out_y SHALL equal reduction-OR of out_hits.
REQ-020 Pipeline SHALL be two registered stages: S1 captures term hits, S2 captures hits and out_y.
REQ-021 Latency SHALL be 2 cycles from accept (in_valid&in_ready) to out_valid with no stall.
REQ-022 Throughput SHALL be one sample per cycle while out_ready=1.
REQ-023 A stage SHALL advance when it is empty or its content moves on in the same cycle; in_ready = !S1_valid or S1 advancing.
REQ-024 While out_valid=1 and out_ready=0, out_y and out_hits SHALL hold stable; at most 2 samples are held, no loss or duplication.
REQ-025 Config write SHALL take effect the cycle after cfg_we; sample accepted in the same cycle as cfg_we SHALL use old config.
REQ-026 Samples already in S1/S2 SHALL NOT be affected by later config writes.
REQ-027 cfg_we with cfg_term >= NUM_TERMS SHALL be ignored.
REQ-028 cfg_we and accept in the same cycle SHALL both be honoured.

Reset
REQ-029 With rst_n=0 at a clock edge, all terms SHALL become disabled with masks 0, S1/S2 valid cleared.
REQ-030 During and after reset: out_valid=0, out_y=0, out_hits=0; in_ready=0 while rst_n=0, 1 on first cycle after.
REQ-031 Reset mid-operation SHALL discard in-flight samples; no out_valid for them afterwards.

Structure
REQ-032 Shared package sop_pkg SHALL hold the term-config struct type (pos, neg, en) and default parameter constants.
REQ-033 Sub-module sop_term (combinational single-term match) SHALL be instantiated NUM_TERMS times; config storage and pipeline in sop_eval.

Verification
REQ-034 Program T0=in4&!in3&!in2, T1=in4&in3&in0, T2=!in3&in2, T3=in2&!in1; send in_data=5'b01101 -> 2 cycles later out_y=1, out_hits=6'b001000.
REQ-035 Same config, in_data=5'b00000 -> out_y=0, out_hits=0; in_data=5'b11001 -> out_hits=6'b000010, out_y=1.
REQ-036 Stream 8 samples back-to-back, out_ready low 3 cycles mid-stream -> all 8 results in order, outputs stable while stalled, in_ready low once both stages full.
REQ-037 Term with pos=neg=5'b00001 enabled -> never hits; enabled term with zero masks -> hits every sample; cfg_term=7 write -> no change.
REQ-038 cfg_we disabling T3 on same cycle as accepting 5'b01101 -> that sample out_y=1, next identical sample out_y=0.
REQ-039 Assert rst_n=0 with 2 samples in flight -> out_valid=0 next cycle, all hits 0 on subsequent samples until reprogrammed.
